wb_sram_target: RTL and testbench
=================================

Name: wb_sram_target

Overview:
Wishbone B4 registered-feedback slave with on-chip SRAM. It is the responder end of the wb_if links that the interconnects drive, and sits on an interconnect slave port as a general-purpose memory target. It supports classic cycles, incrementing and wrapping bursts (CTI/BTE), byte-lane writes and configurable first-beat wait states. Addresses outside the memory window get an ERR response.

Parameters:
WB_ADDR_WIDTH, 32, address width of s.ADR
WB_DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64
MEM_ADDR_BASE, 'h0, byte address of word 0
MEM_SIZE_WORDS, 1024, memory depth in words; must be a power of two
WAIT_STATES, 0, idle cycles before the first ACK/ERR of a cycle; range 0..7

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  reset; synchronous, active-high
s  wb_if.slave  -  Wishbone slave port carrying the signals below
s.ADR  input  WB_ADDR_WIDTH  byte address
s.DAT_W  input  WB_DATA_WIDTH  write data
s.SEL  input  WB_DATA_WIDTH/8  byte lane enables
s.CYC / s.STB / s.WE  input  1  cycle, strobe, write enable
s.CTI  input  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
s.BTE  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
s.DAT_R  output  WB_DATA_WIDTH  read data
s.ACK / s.ERR  output  1  normal and error termination

Behaviour:
- Reset (rst=1 at a posedge):
  - Next cycle: ACK=0, ERR=0, DAT_R=0, FSM=IDLE, wait counter cleared.
  - SRAM contents are not cleared.
  - Reset mid-burst aborts the burst; no write occurs on that edge.
- Word index: widx = (ADR - MEM_ADDR_BASE) >> log2(WB_DATA_WIDTH/8).
  - In range iff ADR >= MEM_ADDR_BASE and widx < MEM_SIZE_WORDS.
  - Low byte-offset bits are ignored.
- FSM state IDLE:
  - When CYC&STB is sampled: latch widx, WE, in-range flag and CTI/BTE.
  - Go to WAIT with counter=WAIT_STATES, or directly to RESP when WAIT_STATES=0.
- FSM state WAIT:
  - Decrement the counter each cycle; at 0 go to RESP.
  - CYC=0 returns to IDLE with no response.
- FSM state RESP:
  - Exactly one of ACK/ERR is high: ERR if out of range, else ACK.
  - Latency: ACK/ERR first asserts WAIT_STATES+1 cycles after the edge that sampled CYC&STB in IDLE.
  - Read: DAT_R = mem[widx] in the ACK cycle; DAT_R=0 with ERR.
  - Write: on the edge ending the ACK cycle (ACK&STB high), mem[widx] lanes with SEL[i]=1 take DAT_W; other lanes are unchanged. No write occurs on ERR.
- Classic cycle (CTI = 000, 001 or reserved values; also ERR, or CTI=111 at the first beat):
  - One ACK/ERR pulse, then IDLE.
  - Back-to-back classic cycles re-enter WAIT, so each cycle pays WAIT_STATES again.
- Burst (CTI=010 at the beat being acknowledged, first beat ACK, not ERR): go to BURST.
  - Next widx comes from an internal counter, not ADR. Linear: +1. Wrap-N: low log2(N) bits increment modulo N, upper bits are held.
  - Each further beat is acknowledged in the following cycle with zero wait states; DAT_R comes from the pre-computed address.
  - ACK = beat_valid & CYC & STB. With STB=0 the counter holds, ACK is low and no write occurs; the burst resumes when STB returns.
  - A beat with CTI=111 is acknowledged, then the FSM returns to IDLE.
  - If the counter leaves the memory window (linear overrun), that beat gets ERR instead of ACK and the FSM returns to IDLE.
- CYC deassert in any state: IDLE next cycle, ACK/ERR low, no write.
- ACK and ERR are never high in the same cycle.

Test Plan:
1. WAIT_STATES=2, classic write 0xDEADBEEF to 0x10, SEL=1111, then classic read of 0x10 -> each ACK rises 3 cycles after STB is sampled; read DAT_R=0xDEADBEEF.
2. Mem word 4 = 0x11223344; write 0xAABBCCDD to 0x10 with SEL=0101, read back -> 0x11BB33DD.
3. Words 8..11 preloaded 0xA0..0xA3, wrap4 read burst starting at 0x28 (word 10), 4 beats, CTI=111 on beat 4 -> data A2,A3,A0,A1; one ACK per cycle after the first; IDLE afterwards.
4. Linear write burst from 0x0; STB=0 for 2 cycles after beat 2 -> ACK low during the stall, no write; beats 3-4 land at words 2-3.
5. Classic read of MEM_ADDR_BASE+4*MEM_SIZE_WORDS -> ERR for 1 cycle, ACK=0, DAT_R=0; linear burst started at the last word -> beat 1 ACK, beat 2 ERR.
6. CYC dropped mid-burst, and rst pulsed mid-WAIT -> ACK/ERR=0 next cycle, FSM IDLE, memory unchanged; a new classic read then succeeds.

Source files
------------

// File: rtl/wb_sram_target_if.sv
// Wishbone B4 link bundle shared by interconnect masters and memory targets.
// The master drives address/data/control; the slave returns data and termination.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   ADR;
  logic [DW-1:0]   DAT_W;
  logic [DW-1:0]   DAT_R;
  logic [DW/8-1:0] SEL;
  logic            CYC;
  logic            STB;
  logic            WE;
  logic [2:0]      CTI;
  logic [1:0]      BTE;
  logic            ACK;
  logic            ERR;

  modport master (
    output ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, DAT_W, SEL, CYC, STB, WE, CTI, BTE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_target.sv
// Wishbone B4 registered-feedback SRAM target with classic and CTI/BTE bursts.
// Out-of-window accesses and linear burst overruns terminate with ERR.
module wb_sram_target #(
  parameter int                       WB_ADDR_WIDTH  = 32,
  parameter int                       WB_DATA_WIDTH  = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] MEM_ADDR_BASE  = '0,
  parameter int                       MEM_SIZE_WORDS = 1024,
  parameter int                       WAIT_STATES    = 0
) (
  input logic clk,
  input logic rst,
  wb_if.slave s
);

  localparam int NB  = WB_DATA_WIDTH / 8;
  localparam int SH  = $clog2(NB);
  localparam int MAW = $clog2(MEM_SIZE_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_BURST
  } state_e;

  logic [WB_DATA_WIDTH-1:0] mem [MEM_SIZE_WORDS];

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [MAW-1:0]   widx_q, widx_d;
  logic             inr_q, inr_d;
  logic             we_q, we_d;
  logic [1:0]       bte_q, bte_d;

  logic [WB_ADDR_WIDTH-1:0] off;
  logic [WB_ADDR_WIDTH-1:0] widx_full;
  logic                     adr_inr;

  assign off       = s.ADR - MEM_ADDR_BASE;
  assign widx_full = off >> SH;
  assign adr_inr   = (s.ADR >= MEM_ADDR_BASE) &&
                     ((widx_full >> MAW) == '0);

  logic [MAW-1:0] wmask;
  logic [MAW:0]   lin_nxt;
  logic [MAW-1:0] widx_inc;
  logic           nxt_inr;

  // Wrap bursts only advance the low bits; linear may run off the end.
  always_comb begin
    unique case (bte_q)
      2'b01:   wmask = MAW'(3);
      2'b10:   wmask = MAW'(7);
      2'b11:   wmask = MAW'(15);
      default: wmask = '1;
    endcase
    lin_nxt  = {1'b0, widx_q} + (MAW+1)'(1);
    widx_inc = (widx_q & ~wmask) | (lin_nxt[MAW-1:0] & wmask);
    nxt_inr  = (bte_q != 2'b00) || !lin_nxt[MAW];
  end

  logic beat;
  logic ack;
  logic err;
  logic wr_en;

  assign beat  = ((state_q == S_RESP) || (state_q == S_BURST)) &&
                 s.CYC && s.STB;
  assign ack   = beat && inr_q;
  assign err   = beat && !inr_q;
  assign wr_en = ack && we_q && !rst;

  assign s.ACK   = ack;
  assign s.ERR   = err;
  assign s.DAT_R = ack ? mem[widx_q] : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    inr_d   = inr_q;
    we_d    = we_q;
    bte_d   = bte_q;
    unique case (state_q)
      S_IDLE: begin
        if (s.CYC && s.STB) begin
          widx_d  = widx_full[MAW-1:0];
          inr_d   = adr_inr;
          we_d    = s.WE;
          bte_d   = s.BTE;
          cnt_d   = 3'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_RESP, S_BURST: begin
        if (beat) begin
          if (ack && (s.CTI == 3'b010)) begin
            state_d = S_BURST;
            widx_d  = widx_inc;
            inr_d   = nxt_inr;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!s.CYC) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      inr_q   <= 1'b0;
      we_q    <= 1'b0;
      bte_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      inr_q   <= inr_d;
      we_q    <= we_d;
      bte_q   <= bte_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (s.SEL[i]) mem[widx_q][8*i +: 8] <= s.DAT_W[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_target.sv
// Randomized bench for wb_sram_target against a word-array reference model.
// Directed cases cover wait states, lanes, wrap/linear bursts, stalls and aborts.
module tb_wb_sram_target;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 64;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_if #(.AW(AW), .DW(DW)) bus ();

  wb_sram_target #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .MEM_ADDR_BASE (32'h0),
    .MEM_SIZE_WORDS(NW),
    .WAIT_STATES   (WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s  (bus)
  );

  logic [31:0] model [NW];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic drive_idle();
    bus.CYC   = 1'b0;
    bus.STB   = 1'b0;
    bus.WE    = 1'b0;
    bus.ADR   = '0;
    bus.DAT_W = '0;
    bus.SEL   = '0;
    bus.CTI   = 3'b000;
    bus.BTE   = 2'b00;
  endtask

  // One Wishbone cycle: classic (burst=0) or burst of nbeats.
  task automatic xfer(input bit          we,
                      input logic [31:0] adr,
                      input logic [31:0] d0,
                      input logic [3:0]  s0,
                      input bit          burst,
                      input logic [1:0]  bte,
                      input int          nbeats,
                      input int          stall_at,
                      input int          stall_n,
                      input int          abort_at);
    int          idx;
    int          wn;
    int          lat;
    bit          inr;
    bit          a;
    bit          e;
    logic [31:0] cd;
    logic [3:0]  cs;
    idx = int'(adr >> 2);
    inr = (idx < NW);
    cd  = d0;
    cs  = s0;
    wn  = (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : 16;
    @(posedge clk); #1;
    bus.CYC   = 1'b1;
    bus.STB   = 1'b1;
    bus.WE    = we;
    bus.ADR   = adr;
    bus.BTE   = bte;
    bus.DAT_W = cd;
    bus.SEL   = cs;
    bus.CTI   = !burst ? 3'b000 : (nbeats == 1) ? 3'b111 : 3'b010;
    @(posedge clk);
    lat = 0;
    a   = 1'b0;
    e   = 1'b0;
    while (!(a || e) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      a = bus.ACK;
      e = bus.ERR;
    end
    chk("first_latency", 64'(lat), 64'(WS + 1));
    for (int b = 0; b < nbeats; b++) begin
      chk("ack", 64'(a), 64'(inr));
      chk("err", 64'(e), 64'(!inr));
      chk("ack_err_excl", 64'(a && e), 64'd0);
      if (!we || !inr)
        chk("dat_r", 64'(bus.DAT_R), inr ? 64'(model[idx]) : 64'd0);
      if (!(a || e)) begin
        @(posedge clk); #1;
        drive_idle();
        break;
      end
      @(posedge clk);
      if (we && inr) model[idx] = merge(model[idx], cd, cs);
      #1;
      if (!inr || !burst || b == nbeats - 1 || b == abort_at) begin
        drive_idle();
        break;
      end
      if (bte == 2'b00) idx = idx + 1;
      else idx = (idx & ~(wn - 1)) | ((idx + 1) & (wn - 1));
      inr = (idx < NW);
      if (b == stall_at) begin
        bus.STB = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          chk("stall_ack", 64'(bus.ACK), 64'd0);
          chk("stall_err", 64'(bus.ERR), 64'd0);
          @(posedge clk); #1;
        end
        bus.STB = 1'b1;
      end
      cd        = $urandom;
      cs        = 4'($urandom_range(0, 15));
      bus.ADR   = 32'(idx) << 2;
      bus.DAT_W = cd;
      bus.SEL   = cs;
      bus.CTI   = (b + 1 == nbeats - 1) ? 3'b111 : 3'b010;
      @(negedge clk);
      a = bus.ACK;
      e = bus.ERR;
    end
    @(negedge clk);
    chk("idle_ack", 64'(bus.ACK), 64'd0);
    chk("idle_err", 64'(bus.ERR), 64'd0);
  endtask

  task automatic wr(input logic [31:0] adr,
                    input logic [31:0] d,
                    input logic [3:0]  s);
    xfer(1'b1, adr, d, s, 1'b0, 2'b00, 1, -1, 0, -1);
  endtask

  task automatic rd(input logic [31:0] adr);
    xfer(1'b0, adr, 32'h0, 4'hF, 1'b0, 2'b00, 1, -1, 0, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_idle();
    bus.CYC = 1'b1;
    bus.STB = 1'b1;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    chk("reset_ack", 64'(bus.ACK), 64'd0);
    chk("reset_err", 64'(bus.ERR), 64'd0);
    chk("reset_dat_r", 64'(bus.DAT_R), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NW; i++) wr(32'(i) << 2, $urandom, 4'hF);

    wr(32'h10, 32'hDEADBEEF, 4'hF);
    rd(32'h10);

    wr(32'h10, 32'h11223344, 4'hF);
    wr(32'h10, 32'hAABBCCDD, 4'b0101);
    rd(32'h12);

    for (int i = 0; i < 4; i++)
      wr(32'(8 + i) << 2, 32'hA0 + 32'(i), 4'hF);
    xfer(1'b0, 32'h28, 32'h0, 4'hF, 1'b1, 2'b01, 4, -1, 0, -1);
    rd(32'h20);

    xfer(1'b1, 32'h0, $urandom, 4'hF, 1'b1, 2'b00, 4, 1, 2, -1);
    xfer(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 2'b00, 4, -1, 0, -1);

    rd(32'(NW * 4));
    xfer(1'b0, 32'(NW * 4 - 4), 32'h0, 4'hF, 1'b1, 2'b00, 3, -1, 0, -1);
    xfer(1'b1, 32'(NW * 4 - 4), $urandom, 4'hF, 1'b1, 2'b00, 3, -1, 0, -1);

    xfer(1'b1, 32'h40, $urandom, 4'hF, 1'b1, 2'b00, 6, -1, 0, 1);
    xfer(1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 2'b00, 4, -1, 0, -1);

    @(posedge clk); #1;
    bus.CYC   = 1'b1;
    bus.STB   = 1'b1;
    bus.WE    = 1'b1;
    bus.ADR   = 32'h20;
    bus.DAT_W = 32'h5555AAAA;
    bus.SEL   = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk("rst_wait_ack", 64'(bus.ACK), 64'd0);
    chk("rst_wait_err", 64'(bus.ERR), 64'd0);
    chk("rst_wait_dat", 64'(bus.DAT_R), 64'd0);
    rd(32'h20);

    @(posedge clk); #1;
    bus.CYC   = 1'b1;
    bus.STB   = 1'b1;
    bus.WE    = 1'b1;
    bus.ADR   = 32'h24;
    bus.DAT_W = 32'h12345678;
    bus.SEL   = 4'hF;
    @(posedge clk); #1;
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cyc_drop_ack", 64'(bus.ACK), 64'd0);
    end
    rd(32'h24);

    for (int t = 0; t < 80; t++) begin
      bit          we;
      bit          bst;
      logic [31:0] adr;
      logic [1:0]  bte;
      int          nb;
      int          st;
      int          ab;
      we  = 1'($urandom_range(0, 1));
      bst = ($urandom_range(0, 2) != 0);
      adr = 32'($urandom_range(0, NW * 4 + 15));
      bte = 2'($urandom_range(0, 3));
      nb  = bst ? $urandom_range(1, 8) : 1;
      st  = $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : -1;
      ab  = $urandom_range(0, 9) == 0 ? $urandom_range(0, 3) : -1;
      xfer(we, adr, $urandom, 4'($urandom_range(0, 15)),
           bst, bte, nb, st, $urandom_range(1, 3), ab);
    end

    for (int i = 0; i < NW; i += 8) rd(32'(i) << 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
